// File: rtl/obj_fetch_scheduler_pkg.sv
// rtl/obj_fetch_scheduler_pkg.sv - shared types for the object fetch scheduler (package render_pkg)
package render_pkg;

  localparam int DEF_FACET_ADDR_W = 12;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    ISSUE,
    WAIT,
    DONE
  } sched_state_t;

  typedef struct packed {
    logic [DEF_FACET_ADDR_W-1:0] base;
    logic [DEF_FACET_ADDR_W-1:0] count;
  } obj_desc_t;

endpackage

// File: rtl/obj_fetch_scheduler_if.sv
// rtl/obj_fetch_scheduler_if.sv - request/triangle bus between scheduler (master) and fetch engine (slave)
interface obj_fetch_scheduler_if #(
  parameter int FACET_ADDR_W = 12
);
  logic                    req_valid_out;
  logic                    req_ready_in;
  logic [FACET_ADDR_W-1:0] req_base_out;
  logic [FACET_ADDR_W-1:0] req_count_out;
  logic                    tri_valid_in;
  logic                    fetch_done_in;

  modport master (
    output req_valid_out, req_base_out, req_count_out,
    input  req_ready_in, tri_valid_in, fetch_done_in
  );

  modport slave (
    input  req_valid_out, req_base_out, req_count_out,
    output req_ready_in, tri_valid_in, fetch_done_in
  );
endinterface

// File: rtl/obj_fetch_scheduler_desc_table.sv
// rtl/obj_fetch_scheduler_desc_table.sv - object descriptor register file, one write port, async read
module obj_desc_table #(
  parameter int NUM_OBJECTS  = 8,
  parameter int FACET_ADDR_W = 12
) (
  input  logic                           clk_in,
  input  logic                           rst_n_in,
  input  logic                           i_wr_en,
  input  logic [$clog2(NUM_OBJECTS)-1:0] i_wr_idx,
  input  logic [FACET_ADDR_W-1:0]        i_wr_base,
  input  logic [FACET_ADDR_W-1:0]        i_wr_count,
  input  logic [$clog2(NUM_OBJECTS)-1:0] i_rd_idx,
  output logic [FACET_ADDR_W-1:0]        o_rd_base,
  output logic [FACET_ADDR_W-1:0]        o_rd_count
);

  logic [FACET_ADDR_W-1:0] r_base  [NUM_OBJECTS];
  logic [FACET_ADDR_W-1:0] r_count [NUM_OBJECTS];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < NUM_OBJECTS; i++) begin
        r_base[i]  <= '0;
        r_count[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_base[i_wr_idx]  <= i_wr_base;
      r_count[i_wr_idx] <= i_wr_count;
    end
  end

  assign o_rd_base  = r_base[i_rd_idx];
  assign o_rd_count = r_count[i_rd_idx];

endmodule

// File: rtl/obj_fetch_scheduler.sv
// rtl/obj_fetch_scheduler.sv - frame scheduler sequencing the fetch engine over every enabled object
// Optional SCHED_WATCHDOG_EN adds a per-object ISSUE/WAIT timeout and the wdog_err_out port.
module obj_fetch_scheduler
  import render_pkg::*;
#(
  parameter int NUM_OBJECTS  = 8,
  parameter int FACET_ADDR_W = DEF_FACET_ADDR_W
`ifdef SCHED_WATCHDOG_EN
  ,
  parameter int WDOG_CYCLES  = 4096
`endif
) (
  input  logic                           clk_in,
  input  logic                           rst_n_in,
  input  logic                           frame_start_in,
  input  logic                           cfg_we_in,
  input  logic [$clog2(NUM_OBJECTS)-1:0] cfg_idx_in,
  input  logic [FACET_ADDR_W-1:0]        cfg_base_in,
  input  logic [FACET_ADDR_W-1:0]        cfg_count_in,
  obj_fetch_scheduler_if.master          fetch_if,
  output logic [$clog2(NUM_OBJECTS)-1:0] obj_idx_out,
  output logic                           busy_out,
  output logic                           frame_done_out,
`ifdef SCHED_WATCHDOG_EN
  output logic                           wdog_err_out,
`endif
  output logic                           err_out
);

  localparam int               IDX_W    = $clog2(NUM_OBJECTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBJECTS - 1);

  sched_state_t            r_state;
  logic [IDX_W-1:0]        r_obj_idx;
  logic                    r_busy;
  logic                    r_frame_done;
  logic                    r_err;
  logic                    r_req_valid;
  logic [FACET_ADDR_W-1:0] r_req_base;
  logic [FACET_ADDR_W-1:0] r_req_count;
  logic [FACET_ADDR_W-1:0] r_tri_cnt;

  logic                    w_cfg_we;
  logic                    w_last;
  logic                    w_wdog_fire;
  logic                    w_obj_end;
  logic [FACET_ADDR_W-1:0] w_rd_base;
  logic [FACET_ADDR_W-1:0] w_rd_count;
  logic [FACET_ADDR_W-1:0] w_tri_next;

  // Table only changes between passes so a frame sees one consistent snapshot.
  assign w_cfg_we = cfg_we_in && (r_state == IDLE);

  obj_desc_table #(
    .NUM_OBJECTS  (NUM_OBJECTS),
    .FACET_ADDR_W (FACET_ADDR_W)
  ) u_desc_table (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .i_wr_en    (w_cfg_we),
    .i_wr_idx   (cfg_idx_in),
    .i_wr_base  (cfg_base_in),
    .i_wr_count (cfg_count_in),
    .i_rd_idx   (r_obj_idx),
    .o_rd_base  (w_rd_base),
    .o_rd_count (w_rd_count)
  );

  assign w_last     = (r_obj_idx == LAST_IDX);
  assign w_tri_next = (fetch_if.tri_valid_in && (r_tri_cnt != '1)) ? r_tri_cnt + 1'b1 : r_tri_cnt;
  assign w_obj_end  = w_wdog_fire || ((r_state == WAIT) && fetch_if.fetch_done_in);

`ifdef SCHED_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] r_wdog_cnt;
  logic              r_wdog_err;

  assign w_wdog_fire = ((r_state == ISSUE) || (r_state == WAIT)) &&
                       (r_wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));

  // Counter is zero whenever outside ISSUE/WAIT, so each new object starts fresh.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_wdog_cnt <= '0;
      r_wdog_err <= 1'b0;
    end else begin
      if ((r_state == ISSUE) || (r_state == WAIT)) r_wdog_cnt <= r_wdog_cnt + 1'b1;
      else                                         r_wdog_cnt <= '0;
      if ((r_state == IDLE) && frame_start_in) r_wdog_err <= 1'b0;
      else if (w_wdog_fire)                     r_wdog_err <= 1'b1;
    end
  end

  assign wdog_err_out = r_wdog_err;
`else
  assign w_wdog_fire = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state      <= IDLE;
      r_obj_idx    <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
      r_req_valid  <= 1'b0;
      r_req_base   <= '0;
      r_req_count  <= '0;
      r_tri_cnt    <= '0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (frame_start_in) begin
            r_state   <= LOOKUP;
            r_obj_idx <= '0;
            r_busy    <= 1'b1;
            r_err     <= 1'b0;
          end
        end
        LOOKUP: begin
          if (w_rd_count == '0) begin
            if (w_last) begin
              r_state      <= DONE;
              r_frame_done <= 1'b1;
            end else begin
              r_obj_idx <= r_obj_idx + 1'b1;
            end
          end else begin
            r_req_base  <= w_rd_base;
            r_req_count <= w_rd_count;
            r_req_valid <= 1'b1;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (fetch_if.req_ready_in || w_wdog_fire) r_req_valid <= 1'b0;
          if (fetch_if.req_ready_in) begin
            r_tri_cnt <= '0;
            r_state   <= WAIT;
          end
        end
        WAIT: begin
          r_tri_cnt <= w_tri_next;
          if (fetch_if.fetch_done_in && (w_tri_next != r_req_count)) r_err <= 1'b1;
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      if (w_wdog_fire) r_err <= 1'b1;

      // Common advance for a finished (or timed-out) object; overrides the case above.
      if (w_obj_end) begin
        if (w_last) begin
          r_state      <= DONE;
          r_frame_done <= 1'b1;
        end else begin
          r_obj_idx <= r_obj_idx + 1'b1;
          r_state   <= LOOKUP;
        end
      end
    end
  end

  assign fetch_if.req_valid_out = r_req_valid;
  assign fetch_if.req_base_out  = r_req_base;
  assign fetch_if.req_count_out = r_req_count;
  assign obj_idx_out            = r_obj_idx;
  assign busy_out               = r_busy;
  assign frame_done_out         = r_frame_done;
  assign err_out                = r_err;

endmodule

// File: tb/tb_obj_fetch_scheduler.sv
// tb/tb_obj_fetch_scheduler.sv - directed self-checking bench for obj_fetch_scheduler
module tb_obj_fetch_scheduler;
  import render_pkg::*;

  localparam int NOBJ = 8;
  localparam int AW   = 12;
  localparam int IW   = 3;

  logic          clk_in = 1'b0;
  logic          rst_n_in = 1'b0;
  logic          frame_start_in = 1'b0;
  logic          cfg_we_in = 1'b0;
  logic [IW-1:0] cfg_idx_in = '0;
  logic [AW-1:0] cfg_base_in = '0;
  logic [AW-1:0] cfg_count_in = '0;
  logic [IW-1:0] obj_idx_out;
  logic          busy_out;
  logic          frame_done_out;
  logic          err_out;
`ifdef SCHED_WATCHDOG_EN
  logic          wdog_err_out;
`endif

  int checks = 0;
  int errors = 0;

  obj_fetch_scheduler_if #(.FACET_ADDR_W(AW)) bus ();

  obj_fetch_scheduler #(
    .NUM_OBJECTS  (NOBJ),
    .FACET_ADDR_W (AW)
`ifdef SCHED_WATCHDOG_EN
    ,
    .WDOG_CYCLES  (16)
`endif
  ) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .frame_start_in (frame_start_in),
    .cfg_we_in      (cfg_we_in),
    .cfg_idx_in     (cfg_idx_in),
    .cfg_base_in    (cfg_base_in),
    .cfg_count_in   (cfg_count_in),
    .fetch_if       (bus),
    .obj_idx_out    (obj_idx_out),
    .busy_out       (busy_out),
    .frame_done_out (frame_done_out),
`ifdef SCHED_WATCHDOG_EN
    .wdog_err_out   (wdog_err_out),
`endif
    .err_out        (err_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic cfg_write(input int idx, input obj_desc_t d);
    cfg_we_in    = 1'b1;
    cfg_idx_in   = IW'(idx);
    cfg_base_in  = d.base;
    cfg_count_in = d.count;
    cycle();
    cfg_we_in = 1'b0;
  endtask

  task automatic start_frame();
    frame_start_in = 1'b1;
    cycle();
    frame_start_in = 1'b0;
  endtask

  task automatic wait_req(input string tag, input int max);
    int n = 0;
    while (!bus.req_valid_out && n < max) begin
      cycle();
      n++;
    end
    check(tag, bus.req_valid_out, 1);
  endtask

  task automatic wait_done(input string tag, input int max);
    int n = 0;
    while (!frame_done_out && n < max) begin
      cycle();
      n++;
    end
    check(tag, frame_done_out, 1);
  endtask

  // Expects req_valid_out already high; holds ready low for 'delay' cycles, then returns ntri triangles.
  task automatic serve(input string tag, input obj_desc_t d, input int delay, input int ntri);
    check({tag, "_base"}, bus.req_base_out, d.base);
    check({tag, "_count"}, bus.req_count_out, d.count);
    for (int i = 0; i < delay; i++) begin
      cycle();
      check({tag, "_hold_valid"}, bus.req_valid_out, 1);
      check({tag, "_hold_base"}, bus.req_base_out, d.base);
      check({tag, "_hold_count"}, bus.req_count_out, d.count);
    end
    bus.req_ready_in = 1'b1;
    cycle();
    bus.req_ready_in = 1'b0;
    check({tag, "_valid_drop"}, bus.req_valid_out, 0);
    if (ntri == 0) begin
      bus.fetch_done_in = 1'b1;
      cycle();
    end else begin
      for (int i = 0; i < ntri; i++) begin
        bus.tri_valid_in  = 1'b1;
        bus.fetch_done_in = (i == ntri - 1);
        cycle();
      end
    end
    bus.tri_valid_in  = 1'b0;
    bus.fetch_done_in = 1'b0;
  endtask

  // All-disabled pass: done pulse exactly NOBJ+1 cycles after the start cycle, with a stray start while busy.
  task automatic empty_frame(input string tag);
    int n;
    logic seen_req;
    start_frame();
    n = 1;
    seen_req = 1'b0;
    while (!frame_done_out && n < 20) begin
      if (bus.req_valid_out) seen_req = 1'b1;
      if (n == 3) frame_start_in = 1'b1;
      cycle();
      frame_start_in = 1'b0;
      n++;
    end
    check({tag, "_latency"}, n, NOBJ + 1);
    check({tag, "_no_req"}, seen_req, 0);
    repeat (3) cycle();
    check({tag, "_busy_after"}, busy_out, 0);
    check({tag, "_no_extra_done"}, frame_done_out, 0);
  endtask

  initial begin
    bus.req_ready_in  = 1'b0;
    bus.tri_valid_in  = 1'b0;
    bus.fetch_done_in = 1'b0;

    repeat (3) cycle();
    check("rst_busy", busy_out, 0);
    check("rst_valid", bus.req_valid_out, 0);
    check("rst_done", frame_done_out, 0);
    check("rst_err", err_out, 0);
    check("rst_idx", obj_idx_out, 0);
    rst_n_in = 1'b1;
    cycle();

    // Frame A: obj0 {0,12}, obj2 {12,6}, exact triangle counts.
    cfg_write(0, '{base: 12'd0, count: 12'd12});
    cfg_write(2, '{base: 12'd12, count: 12'd6});
    start_frame();
    check("a_busy", busy_out, 1);
    check("a_valid_early", bus.req_valid_out, 0);
    cycle();
    check("a_valid_2cyc", bus.req_valid_out, 1);
    check("a_idx0", obj_idx_out, 0);
    serve("a_obj0", '{base: 12'd0, count: 12'd12}, 0, 12);
    wait_req("a_req2", 10);
    check("a_idx2", obj_idx_out, 2);
    serve("a_obj2", '{base: 12'd12, count: 12'd6}, 0, 6);
    wait_done("a_done", 20);
    check("a_err", err_out, 0);
    cycle();
    check("a_done_pulse", frame_done_out, 0);
    check("a_busy_end", busy_out, 0);

    // Frame B: obj0 short by one triangle, obj2 held off for 5 cycles.
    start_frame();
    wait_req("b_req0", 5);
    serve("b_obj0", '{base: 12'd0, count: 12'd12}, 0, 11);
    check("b_err_set", err_out, 1);
    wait_req("b_req2", 10);
    check("b_idx2", obj_idx_out, 2);
    serve("b_obj2", '{base: 12'd12, count: 12'd6}, 5, 6);
    wait_done("b_done", 20);
    check("b_err_sticky", err_out, 1);
    cycle();

    // Frame C: disable obj0 in the same cycle as start; a mid-pass write to obj5 must be dropped.
    cfg_we_in      = 1'b1;
    cfg_idx_in     = 3'd0;
    cfg_base_in    = 12'd0;
    cfg_count_in   = 12'd0;
    frame_start_in = 1'b1;
    cycle();
    frame_start_in = 1'b0;
    cfg_we_in      = 1'b0;
    check("c_err_clear", err_out, 0);
    cfg_write(5, '{base: 12'd100, count: 12'd3});
    wait_req("c_req", 10);
    check("c_idx_skip", obj_idx_out, 2);
    serve("c_obj2", '{base: 12'd12, count: 12'd6}, 0, 6);
    wait_done("c_done", 20);
    check("c_err", err_out, 0);
    cycle();

    // Frame D: every descriptor zero.
    cfg_write(2, '{base: 12'd0, count: 12'd0});
    empty_frame("d");

    // Asynchronous reset in the middle of WAIT.
    cfg_write(1, '{base: 12'd40, count: 12'd3});
    start_frame();
    wait_req("r_req", 10);
    check("r_idx1", obj_idx_out, 1);
    bus.req_ready_in = 1'b1;
    cycle();
    bus.req_ready_in = 1'b0;
    bus.tri_valid_in = 1'b1;
    cycle();
    bus.tri_valid_in = 1'b0;
    check("r_busy_pre", busy_out, 1);
    rst_n_in = 1'b0;
    #2;
    check("r_busy", busy_out, 0);
    check("r_idx", obj_idx_out, 0);
    check("r_valid", bus.req_valid_out, 0);
    check("r_base", bus.req_base_out, 0);
    check("r_count", bus.req_count_out, 0);
    check("r_done", frame_done_out, 0);
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    cycle();
    empty_frame("r_after");

`ifdef SCHED_WATCHDOG_EN
    begin
      int n;
      cfg_write(0, '{base: 12'd7, count: 12'd2});
      start_frame();
      wait_req("w_req", 5);
      bus.req_ready_in = 1'b1;
      cycle();
      bus.req_ready_in = 1'b0;
      n = 1;
      while (!wdog_err_out && n < 40) begin
        cycle();
        n++;
      end
      check("w_latency", n, 16);
      check("w_wdog_err", wdog_err_out, 1);
      wait_done("w_done", 20);
      check("w_err", err_out, 1);
      cycle();
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/obj_fetch_scheduler.md
Name: obj_fetch_scheduler

Overview:
Frame-level scheduler for the facet/vertex fetch engine, which walks a facet ROM range and emits triangles.
- Holds a small descriptor table of objects, each a facet base address plus a facet count.
- On each frame start it sequences the fetch engine through every non-empty object in index order, one request at a time.
- Checks the triangle count each object returns, and reports frame completion and errors to the raster/transform front end.

Parameters:
NUM_OBJECTS, 8, number of descriptor table entries (power of two, 2..64)
FACET_ADDR_W, 12, facet ROM address width; also the width of base and count

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  reset, asynchronous, active-low
frame_start_in  input  1  single-cycle pulse requesting one pass over the table
cfg_we_in  input  1  descriptor write strobe
cfg_idx_in  input  $clog2(NUM_OBJECTS)  descriptor index
cfg_base_in  input  FACET_ADDR_W  first facet address of the object
cfg_count_in  input  FACET_ADDR_W  number of facets in the object (0 means disabled)
req_valid_out  output  1  fetch request valid
req_ready_in  input  1  fetch engine accepts the request
req_base_out  output  FACET_ADDR_W  request base address
req_count_out  output  FACET_ADDR_W  request facet count
tri_valid_in  input  1  one triangle emitted by the fetch engine
fetch_done_in  input  1  single-cycle pulse: fetch engine finished the current request
obj_idx_out  output  $clog2(NUM_OBJECTS)  index of the object being scheduled
busy_out  output  1  high from frame accept until frame_done_out
frame_done_out  output  1  single-cycle pulse at end of pass
err_out  output  1  sticky count-mismatch flag

Behaviour:
- Clock and reset: one clock, clk_in. rst_n_in is asynchronous and active-low.
- Reset values: all outputs 0, state IDLE, every descriptor cleared to base 0 / count 0, triangle counter 0.
- Reset asserted mid-frame aborts immediately. No frame_done_out is produced for the aborted pass.
- States:
  - IDLE: on frame_start_in go to LOOKUP. In the same edge: obj_idx_out<=0, busy_out<=1, err_out<=0.
  - LOOKUP: read descriptor[obj_idx_out].
    - count==0: if this is the last index go to DONE, otherwise increment the index and stay in LOOKUP (one cycle per skipped object).
    - count!=0: latch base and count into req_base_out / req_count_out, assert req_valid_out, go to ISSUE.
  - ISSUE: hold req_valid_out and the payload stable until req_ready_in. On the handshake cycle, deassert req_valid_out next edge, clear the triangle counter, go to WAIT. First req_valid_out is 2 cycles after frame_start_in.
  - WAIT: increment the triangle counter on each tri_valid_in (saturating at all-ones).
    - On fetch_done_in, compare the count including a same-cycle tri_valid_in; a mismatch with req_count_out sets err_out.
    - Then: last index -> DONE, else increment the index and go to LOOKUP.
  - DONE: frame_done_out=1 for one cycle, busy_out<=0, go to IDLE.
- Ignored events:
  - frame_start_in while not in IDLE (no queueing).
  - fetch_done_in and tri_valid_in outside WAIT.
- Descriptor writes:
  - Committed only in IDLE. cfg_we_in at any other time is dropped, so the table is stable across a pass.
  - A write coinciding with frame_start_in in IDLE is committed and is visible to the pass.
- All-disabled table: frame_done_out fires NUM_OBJECTS+1 cycles after frame_start_in, and no request is issued.
- Arithmetic: the index wraps naturally but never advances past NUM_OBJECTS-1; the last-index check prevents it. The count comparison is unsigned, FACET_ADDR_W bits.

Optional Feature:
SCHED_WATCHDOG_EN
- Defined:
  - Adds parameter WDOG_CYCLES (default 4096) and output wdog_err_out (reset 0, sticky, cleared on frame accept).
  - A cycle counter runs in ISSUE+WAIT for the current object. Reaching WDOG_CYCLES sets wdog_err_out and err_out, then advances as if fetch_done_in had arrived.
  - The counter reloads on each transition into ISSUE.
- Undefined: no counter and no port. The scheduler waits indefinitely in ISSUE/WAIT.

Decomposition:
- Package render_pkg:
  - sched_state_t enum {IDLE, LOOKUP, ISSUE, WAIT, DONE}
  - obj_desc_t packed struct {base, count}
  - localparam FACET_ADDR_W default
- Sub-module obj_desc_table: NUM_OBJECTS x obj_desc_t register file with a write port and a combinational read port, clearing on async reset.
- The FSM and counters stay in the top module.

Test Plan:
- Configure obj0 {0,12} and obj2 {12,6}, others 0; pulse frame_start_in, engine ready=1 and returning the exact triangle counts -> two requests (0,12) then (12,6), obj_idx_out 0 then 2, one frame_done_out, err_out=0.
- Hold req_ready_in low for 5 cycles -> req_valid_out and payload constant for 6 cycles, single accept, no duplicate request.
- Engine returns 11 triangles for count 12 -> err_out=1 after fetch_done_in, stays 1 through frame_done_out, clears on the next frame_start_in.
- All descriptors 0 -> frame_done_out exactly NUM_OBJECTS+1 (9) cycles after frame_start_in, req_valid_out never high; a second frame_start_in while busy is ignored.
- Pulse rst_n_in low mid-WAIT -> all outputs 0 asynchronously, table cleared, next frame issues no requests.
- With SCHED_WATCHDOG_EN and WDOG_CYCLES=16, engine never pulses fetch_done_in -> wdog_err_out=1 after 16 cycles, scheduler advances and frame_done_out is still produced.
